rr_arbiter_4: RTL and testbench

Four-way round-robin arbiter that shares a single resource between requesters 0-3 and drives a one-hot grant vector, the sequential counterpart of the 2-to-4 one-hot select decode. It sits in front of a shared datapath resource: requesters raise `req`, the arbiter issues exactly one grant at a time and rotates priority so no requester starves. An optional hold timeout preempts an owner that keeps its request asserted for too long.

---
 rtl/rr_arbiter_4.sv | 151 +++++++++++++++
 tb/tb_rr_arbiter_4.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with registered one-hot grant and rotating priority pointer.
// Optional hold timeout that preempts a long-running owner: define RR_ARB_TIMEOUT_EN.
module rr_arbiter_4 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] grant_idx,
    output logic       grant_valid
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arbiter_4: MAX_HOLD must be in 1..255");
    end

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] grant_idx_q, grant_idx_d;
    logic       grant_valid_q, grant_valid_d;
`ifdef RR_ARB_TIMEOUT_EN
    logic [7:0] hold_cnt_q, hold_cnt_d;
`endif

    logic [1:0] next_ptr;
    logic [3:0] owner_mask;
    logic [3:0] others_req;
    logic [1:0] win_from_ptr;
    logic [1:0] win_from_next;

    function automatic logic [1:0] scan(input logic [1:0] base, input logic [3:0] r);
        logic [1:0] win;
        logic [1:0] idx;
        logic       found;
        win   = base;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = base + 2'(i);
            if (!found && r[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    function automatic logic [3:0] decode(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    assign next_ptr      = grant_idx_q + 2'd1;
    assign owner_mask    = decode(grant_idx_q);
    assign others_req    = req & ~owner_mask;
    assign win_from_ptr  = scan(ptr_q, req);
    assign win_from_next = scan(next_ptr, others_req);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
`ifdef RR_ARB_TIMEOUT_EN
        hold_cnt_d  = hold_cnt_q;
`endif
        if (!en) begin
            // Disable wins over a simultaneous release, but the pointer still rotates.
            state_d = IDLE;
            grant_d = 4'b0000;
            if (state_q == GRANT && !req[grant_idx_q]) begin
                ptr_d = next_ptr;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|req) begin
                        state_d     = GRANT;
                        grant_idx_d = win_from_ptr;
                        grant_d     = decode(win_from_ptr);
`ifdef RR_ARB_TIMEOUT_EN
                        hold_cnt_d  = 8'd0;
`endif
                    end
                end
                GRANT: begin
                    if (req[grant_idx_q]) begin
`ifdef RR_ARB_TIMEOUT_EN
                        // >= so a requester arriving after the count saturates still preempts.
                        if (hold_cnt_q >= 8'(MAX_HOLD - 1) && |others_req) begin
                            ptr_d       = next_ptr;
                            grant_idx_d = win_from_next;
                            grant_d     = decode(win_from_next);
                            hold_cnt_d  = 8'd0;
                        end else if (hold_cnt_q != 8'hFF) begin
                            hold_cnt_d = hold_cnt_q + 8'd1;
                        end
`endif
                    end else begin
                        ptr_d = next_ptr;
                        if (|others_req) begin
                            grant_idx_d = win_from_next;
                            grant_d     = decode(win_from_next);
`ifdef RR_ARB_TIMEOUT_EN
                            hold_cnt_d  = 8'd0;
`endif
                        end else begin
                            state_d = IDLE;
                            grant_d = 4'b0000;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        grant_valid_d = |grant_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= 2'd0;
            grant_q       <= 4'b0000;
            grant_idx_q   <= 2'd0;
            grant_valid_q <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt_q    <= 8'd0;
`endif
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_q       <= grant_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt_q    <= hold_cnt_d;
`endif
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;
    assign grant_valid = grant_valid_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed table plus hand-written sequences for the four-way round-robin arbiter.
module tb_rr_arbiter_4;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_valid;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       en;
        logic [3:0] req;
        logic [3:0] exp_grant;
        logic [1:0] exp_idx;
        logic       exp_valid;
    } vec_t;

    vec_t vecs[18];

    rr_arbiter_4 #(.MAX_HOLD(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .req        (req),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic e, input logic [3:0] r);
        en  = e;
        req = r;
        tick();
    endtask

    task automatic checkOutput(input string name, input logic [3:0] eg,
                               input logic [1:0] ei, input logic ev);
        checks++;
        if (grant !== eg || grant_idx !== ei || grant_valid !== ev) begin
            failures++;
            $display("[TB] FAIL %s: got grant=%b idx=%0d valid=%b, expected grant=%b idx=%0d valid=%b",
                     name, grant, grant_idx, grant_valid, eg, ei, ev);
        end
    endtask

    task automatic checkGrant(input string name, input logic [3:0] eg);
        checks++;
        if (grant !== eg) begin
            failures++;
            $display("[TB] FAIL %s: got grant=%b, expected %b", name, grant, eg);
        end
    endtask

    task automatic doReset();
        en  = 1'b0;
        req = 4'b0000;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        logic [3:0] exp;
        logic [3:0] rnd_req;

        vecs[0]  = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1};
        vecs[1]  = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1};
        vecs[2]  = '{1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0};
        vecs[3]  = '{1'b1, 4'b0011, 4'b0001, 2'd0, 1'b1};
        vecs[4]  = '{1'b1, 4'b0011, 4'b0001, 2'd0, 1'b1};
        vecs[5]  = '{1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1};
        vecs[6]  = '{1'b1, 4'b0011, 4'b0010, 2'd1, 1'b1};
        vecs[7]  = '{1'b1, 4'b0001, 4'b0001, 2'd0, 1'b1};
        vecs[8]  = '{1'b1, 4'b1001, 4'b0001, 2'd0, 1'b1};
        vecs[9]  = '{1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1};
        vecs[10] = '{1'b0, 4'b1000, 4'b0000, 2'd3, 1'b0};
        vecs[11] = '{1'b0, 4'b1000, 4'b0000, 2'd3, 1'b0};
        vecs[12] = '{1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1};
        vecs[13] = '{1'b0, 4'b0101, 4'b0000, 2'd3, 1'b0};
        vecs[14] = '{1'b1, 4'b0101, 4'b0001, 2'd0, 1'b1};
        vecs[15] = '{1'b1, 4'b0101, 4'b0001, 2'd0, 1'b1};
        vecs[16] = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1};
        vecs[17] = '{1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0};

        rst = 1'b1;
        en  = 1'b0;
        req = 4'b0000;
        #2;
        checkOutput("reset_async", 4'b0000, 2'd0, 1'b0);
        doReset();
        checkOutput("reset_state", 4'b0000, 2'd0, 1'b0);

        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].en, vecs[i].req);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_grant, vecs[i].exp_idx, vecs[i].exp_valid);
        end

        // Round-robin handover: each owner holds three cycles then drops for one edge.
        doReset();
        applyStimulus(1'b1, 4'b1111);
        for (int k = 0; k < 5; k++) begin
            exp = 4'b0001 << (k % 4);
            for (int c = 0; c < 3; c++) begin
                checkOutput($sformatf("rr_owner%0d_c%0d", k, c), exp, 2'(k % 4), 1'b1);
                if (c < 2) applyStimulus(1'b1, 4'b1111);
            end
            applyStimulus(1'b1, 4'b1111 & ~exp);
        end

        // Asynchronous reset in the middle of a grant.
        doReset();
        applyStimulus(1'b1, 4'b1000);
        checkOutput("pre_async_rst", 4'b1000, 2'd3, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_grant_rst", 4'b0000, 2'd0, 1'b0);
        #1;
        rst = 1'b0;

        // Hold timeout: requester 2 waits behind owner 0.
        doReset();
        applyStimulus(1'b1, 4'b0001);
        checkGrant("to_first", 4'b0001);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, 4'b0101);
            checkGrant($sformatf("to_hold%0d", c), 4'b0001);
        end
        applyStimulus(1'b1, 4'b0101);
`ifdef RR_ARB_TIMEOUT_EN
        checkOutput("to_preempt", 4'b0100, 2'd2, 1'b1);
`else
        checkOutput("to_no_preempt", 4'b0001, 2'd0, 1'b1);
`endif

        // Lone owner keeps its grant indefinitely.
        doReset();
        for (int c = 0; c < 22; c++) begin
            applyStimulus(1'b1, 4'b0001);
            checkOutput($sformatf("lone_hold%0d", c), 4'b0001, 2'd0, 1'b1);
        end

        // Random traffic: grant must stay zero or one-hot and agree with idx/valid.
        doReset();
        for (int c = 0; c < 2000; c++) begin
            rnd_req = 4'($urandom_range(0, 15));
            applyStimulus(($urandom_range(0, 7) != 0), rnd_req);
            checks++;
            if ($countones(grant) > 1 || grant_valid !== (|grant) ||
                (grant != 4'b0000 && grant !== (4'b0001 << grant_idx))) begin
                failures++;
                $display("[TB] FAIL invariant cycle %0d: grant=%b idx=%0d valid=%b, required one-hot consistent",
                         c, grant, grant_idx, grant_valid);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
